// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: sequencer state encoding, default vectors, branch offset helper.
`default_nettype none

package mips_pkg;

   typedef enum logic [1:0] {
      ST_BOOT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_HALTED = 2'd2
   } pc_state_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h8000_0180;

   // Signed word offset turned into a byte offset; the adder wraps mod 2^32.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm);
      return {{14{imm[15]}}, imm, 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_target_mux.sv
// Combinational next-PC target selection: jump_reg > jump > branch_taken > pc_plus4.
`default_nettype none

module pc_target_mux
   import mips_pkg::*;
(
   input  logic [31:0] pc_i,
   input  logic        branch_taken_i,
   input  logic [15:0] branch_imm_i,
   input  logic        jump_i,
   input  logic [25:0] jump_index_i,
   input  logic        jump_reg_i,
   input  logic [31:0] jr_target_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] target_o
);

   logic [31:0] branch_tgt;
   logic [31:0] jump_tgt;
   logic [31:0] jr_tgt;
   logic        unused_jr_low;

   assign pc_plus4_o = pc_i + 32'd4;
   assign branch_tgt = pc_plus4_o + branch_offset(branch_imm_i);
   assign jump_tgt   = {pc_plus4_o[31:28], jump_index_i, 2'b00};
   // JR targets are forced word-aligned rather than faulting.
   assign jr_tgt     = {jr_target_i[31:2], 2'b00};

   assign unused_jr_low = ^jr_target_i[1:0];

   always_comb begin
      target_o = pc_plus4_o;
      if (jump_reg_i) begin
         target_o = jr_tgt;
      end else if (jump_i) begin
         target_o = jump_tgt;
      end else if (branch_taken_i) begin
         target_o = branch_tgt;
      end
   end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// Program counter sequencer with BOOT/RUN/HALTED control.
// Define PC_SEQ_TRAP_EN to enable exception redirect to TRAP_VECTOR with EPC capture.
`default_nettype none

module pc_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_imm,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        jump_reg,
   input  logic [31:0] jr_target,
   input  logic        halt,
   input  logic        resume,
   input  logic        exc_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_valid,
   output logic [1:0]  state,
   output logic [31:0] epc
);

   pc_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] target;
   logic        take_trap;

   pc_target_mux u_target_mux (
      .pc_i           (pc_q),
      .branch_taken_i (branch_taken),
      .branch_imm_i   (branch_imm),
      .jump_i         (jump),
      .jump_index_i   (jump_index),
      .jump_reg_i     (jump_reg),
      .jr_target_i    (jr_target),
      .pc_plus4_o     (pc_plus4),
      .target_o       (target)
   );

`ifdef PC_SEQ_TRAP_EN
   // Exceptions override stall; BOOT never traps because inputs are ignored there.
   assign take_trap = exc_req && (state_q != ST_BOOT);
   logic [31:0] trap_target;
   assign trap_target = TRAP_VECTOR;
`else
   logic        unused_trap;
   logic [31:0] trap_target;
   assign take_trap   = 1'b0;
   assign trap_target = RESET_VECTOR;
   assign unused_trap = ^{exc_req, TRAP_VECTOR};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_VECTOR;
         epc_q   <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      epc_d   = epc_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
            pc_d    = RESET_VECTOR;
         end
         ST_RUN: begin
            if (take_trap) begin
               epc_d = pc_q;
               pc_d  = trap_target;
            end else if (!stall) begin
               if (halt) begin
                  state_d = ST_HALTED;
               end else begin
                  pc_d = target;
               end
            end
         end
         ST_HALTED: begin
            if (take_trap) begin
               epc_d   = pc_q;
               pc_d    = trap_target;
               state_d = ST_RUN;
            end else if (!stall && resume) begin
               state_d = ST_RUN;
               pc_d    = pc_plus4;
            end
         end
         default: begin
            state_d = ST_BOOT;
            pc_d    = RESET_VECTOR;
         end
      endcase
   end

   assign pc          = pc_q;
   assign state       = state_q;
   assign epc         = epc_q;
   assign fetch_valid = (state_q == ST_RUN) && !stall;

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value loaded on reset and leaving BOOT.
REQ-002 Parameter TRAP_VECTOR, default 32'h8000_0180: PC redirect target on exception (trap build only).
REQ-003 clk  input  1  rising-edge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 stall  input  1  freezes PC, state, and EPC when high.
REQ-006 branch_taken  input  1  conditional branch resolved taken this cycle.
REQ-007 branch_imm  input  16  signed word offset relative to pc_plus4.
REQ-008 jump  input  1  J/JAL-type absolute jump.
REQ-009 jump_index  input  26  jump word index.
REQ-010 jump_reg  input  1  JR-type register jump.
REQ-011 jr_target  input  32  register jump target.
REQ-012 halt  input  1  halt request from decode.
REQ-013 resume  input  1  leave HALTED.
REQ-014 exc_req  input  1  exception request.
REQ-015 pc  output  32  current fetch address (registered).
REQ-016 pc_plus4  output  32  pc + 4, combinational, mod 2^32.
REQ-017 fetch_valid  output  1  high only in RUN with stall low.
REQ-018 state  output  2  BOOT=0, RUN=1, HALTED=2.
REQ-019 epc  output  32  PC of the excepting instruction.

Function
REQ-020 Three states SHALL exist: BOOT, RUN, HALTED; BOOT SHALL last exactly one cycle, then go to RUN with pc=RESET_VECTOR.
REQ-021 In RUN with stall=0, next-PC priority SHALL be exc_req > halt > jump_reg > jump > branch_taken > pc_plus4.
REQ-022 Branch target SHALL be pc_plus4 + (sign_extend(branch_imm) << 2), wrapping mod 2^32.
REQ-023 Jump target SHALL be {pc_plus4[31:28], jump_index, 2'b00}.
REQ-024 JR target SHALL be {jr_target[31:2], 2'b00}.
REQ-025 On halt in RUN, pc SHALL hold and state SHALL become HALTED next cycle.
REQ-026 In HALTED, pc SHALL hold until resume=1; the next cycle SHALL be RUN with pc=pc_plus4.
REQ-027 Redirects SHALL take effect on the first rising edge after assertion, with one-cycle latency.
REQ-028 stall=1 SHALL block every update except exc_req.
REQ-029 Control inputs SHALL be ignored in BOOT.
REQ-030 If resume and exc_req assert together in HALTED, exc_req SHALL win.

Reset
REQ-031 reset_n=0 SHALL immediately force state=BOOT, pc=RESET_VECTOR, epc=0, and fetch_valid=0, regardless of clk.
REQ-032 Reset asserted mid-halt or mid-redirect SHALL discard the pending state.

Configuration
REQ-033 With macro PC_SEQ_TRAP_EN defined, exc_req SHALL capture epc<=pc and set pc<=TRAP_VECTOR, in both RUN and HALTED and despite stall, ending in RUN.
REQ-034 Without PC_SEQ_TRAP_EN, exc_req SHALL be ignored, epc SHALL be constant 0, and TRAP_VECTOR SHALL be unused.

Structure
REQ-035 The state encoding and default vectors SHALL reside in shared package mips_pkg.
REQ-036 The next-PC target mux SHALL be the combinational sub-module pc_target_mux; the FSM and registers SHALL remain in pc_sequencer.

Verification
REQ-037 Reset release, then 3 idle cycles -> state BOOT then RUN; pc sequence 0, 0, 4, 8; fetch_valid 0, 1, 1, 1.
REQ-038 pc=0x100, branch_taken=1, branch_imm=16'hFFFE -> next pc=0x0FC; branch_imm=16'h0003 from pc=0x100 -> next pc=0x110.
REQ-039 pc=0x3000_0010, jump=1, branch_taken=1, jump_index=26'h40 -> next pc=0x3000_0100 (jump wins); jump_reg=1 with jr_target=0x1237 -> next pc=0x1234.
REQ-040 pc=0xFFFF_FFFC, no control -> next pc=0x0000_0000 (wrap); stall=1 for 3 cycles -> pc held, fetch_valid=0.
REQ-041 halt at pc=0x40 -> HALTED, pc=0x40 held 5 cycles; resume -> RUN, pc=0x44.
REQ-042 Trap build: pc=0x200, stall=1, exc_req=1 -> epc=0x200, pc=0x8000_0180, RUN; non-trap build: same stimulus -> pc=0x200 held, epc=0.
